// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit.
// State encodings are kept as plain localparams for legacy compatibility.
package pipe_ctrl_pkg;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_TRAP = 2'd2;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Fetch redirect/stall control: branch, mret, stalls and interrupt entry.
// Interrupt entry drains EX, captures mepc, then redirects to mtvec.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_jump_flag,
    input  logic [31:0] ex_jump_addr,
    input  logic        ex_mret,
    input  logic        ex_busy,
    input  logic        mem_stall,
    input  logic        irq_req,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_in,
    output logic        jump_flag,
    output logic [31:0] jump_addr,
    output logic        hold,
    output logic        flush,
    output logic        mepc_we,
    output logic [31:0] mepc_out,
    output logic        irq_ack
);

    logic [1:0]  state_q, state_d;
    logic        irq_pend_q, irq_pend_d;
    logic [31:0] mepc_q, mepc_d;

    logic in_trap;
    logic elig;
    logic irq_any;
    logic accept;

    assign in_trap = (state_q == S_TRAP);
    assign elig    = ex_valid & ~ex_busy & ~mem_stall & ~ex_mret;
    assign irq_any = irq_req | irq_pend_q;
    assign accept  = ~in_trap & irq_any & elig;

    always_comb begin
        jump_flag = 1'b0;
        jump_addr = RESET_PC;
        hold      = 1'b0;
        flush     = 1'b0;
        mepc_we   = 1'b0;
        mepc_out  = mepc_q;
        irq_ack   = 1'b0;
        if (in_trap) begin
            jump_flag = 1'b1;
            jump_addr = mtvec;
            flush     = 1'b1;
            hold      = 1'b1;
            mepc_we   = 1'b1;
            irq_ack   = 1'b1;
        end else begin
            if (ex_mret) begin
                jump_flag = 1'b1;
                jump_addr = mepc_in;
                flush     = 1'b1;
            end else if (ex_jump_flag) begin
                jump_flag = 1'b1;
                jump_addr = ex_jump_addr;
                flush     = 1'b1;
            end
            hold = ex_busy | mem_stall;
            if (accept) begin
                hold  = 1'b1;
                flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = S_RUN;
        if (!in_trap) begin
            if (accept) begin
                state_d = S_TRAP;
            end else if (irq_any) begin
                state_d = S_PEND;
            end
        end
    end

    // The accepted request is consumed; a new request during S_TRAP re-arms.
    assign irq_pend_d = (irq_pend_q & ~irq_ack) | (irq_req & ~accept);

    assign mepc_d = accept
                  ? (ex_jump_flag ? ex_jump_addr : next_pc(ex_pc))
                  : mepc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            irq_pend_q <= 1'b0;
            mepc_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            irq_pend_q <= irq_pend_d;
            mepc_q     <= mepc_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl.
// Vectors run back-to-back so FSM state carries between rows.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_jump_flag;
    logic [31:0] ex_jump_addr;
    logic        ex_mret;
    logic        ex_busy;
    logic        mem_stall;
    logic        irq_req;
    logic [31:0] mtvec;
    logic [31:0] mepc_in;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        hold;
    logic        flush;
    logic        mepc_we;
    logic [31:0] mepc_out;
    logic        irq_ack;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_jump_flag (ex_jump_flag),
        .ex_jump_addr (ex_jump_addr),
        .ex_mret      (ex_mret),
        .ex_busy      (ex_busy),
        .mem_stall    (mem_stall),
        .irq_req      (irq_req),
        .mtvec        (mtvec),
        .mepc_in      (mepc_in),
        .jump_flag    (jump_flag),
        .jump_addr    (jump_addr),
        .hold         (hold),
        .flush        (flush),
        .mepc_we      (mepc_we),
        .mepc_out     (mepc_out),
        .irq_ack      (irq_ack)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        valid;
        logic [31:0] pc;
        logic        jf;
        logic [31:0] ja;
        logic        mret;
        logic        busy;
        logic        mstall;
        logic        irq;
        logic [31:0] mepc_i;
        logic        e_jf;
        logic [31:0] e_ja;
        logic        e_hold;
        logic        e_flush;
        logic        e_we;
        logic [31:0] e_mo;
        logic        e_ack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input string nm, input logic r,
        input logic v, input logic [31:0] pc,
        input logic jf, input logic [31:0] ja,
        input logic mr, input logic bz, input logic ms,
        input logic iq, input logic [31:0] mi,
        input logic ejf, input logic [31:0] eja,
        input logic eh, input logic ef, input logic ew,
        input logic [31:0] emo, input logic eak);
        vec_t t;
        t.name = nm; t.rst = r; t.valid = v; t.pc = pc;
        t.jf = jf; t.ja = ja; t.mret = mr; t.busy = bz;
        t.mstall = ms; t.irq = iq; t.mepc_i = mi;
        t.e_jf = ejf; t.e_ja = eja; t.e_hold = eh;
        t.e_flush = ef; t.e_we = ew; t.e_mo = emo; t.e_ack = eak;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        logic [68:0] act;
        logic [68:0] exp;
        @(negedge clk);
        rst          = t.rst;
        ex_valid     = t.valid;
        ex_pc        = t.pc;
        ex_jump_flag = t.jf;
        ex_jump_addr = t.ja;
        ex_mret      = t.mret;
        ex_busy      = t.busy;
        mem_stall    = t.mstall;
        irq_req      = t.irq;
        mepc_in      = t.mepc_i;
        #2;
        act = {jump_flag, jump_addr, hold, flush,
               mepc_we, mepc_out, irq_ack};
        exp = {t.e_jf, t.e_ja, t.e_hold, t.e_flush,
               t.e_we, t.e_mo, t.e_ack};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got jf=%b ja=%h h=%b f=%b we=%b mo=%h ack=%b, want jf=%b ja=%h h=%b f=%b we=%b mo=%h ack=%b",
                     t.name, jump_flag, jump_addr, hold, flush,
                     mepc_we, mepc_out, irq_ack,
                     t.e_jf, t.e_ja, t.e_hold, t.e_flush,
                     t.e_we, t.e_mo, t.e_ack);
        end
    endtask

    initial begin
        rst = 1'b1; ex_valid = 0; ex_pc = 0; ex_jump_flag = 0;
        ex_jump_addr = 0; ex_mret = 0; ex_busy = 0; mem_stall = 0;
        irq_req = 0; mtvec = 32'h200; mepc_in = 32'h1234;
        repeat (2) @(posedge clk);

        //        name        rst v pc          jf ja          mr bz ms iq mepc_in        ejf eja        eh ef ew emo          ak
        tbl.push_back(mk("reset_idle", 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h1234,  0, 32'h0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(mk("branch",     0, 1, 32'h8, 1, 32'h100, 0, 0, 0, 0, 32'h1234, 1, 32'h100, 0, 1, 0, 32'h0, 0));
        tbl.push_back(mk("stall_jump", 0, 1, 32'hC, 1, 32'h40, 0, 0, 1, 0, 32'h1234,  1, 32'h40, 1, 1, 0, 32'h0, 0));
        tbl.push_back(mk("stall_only", 0, 1, 32'hC, 0, 32'h0, 0, 0, 1, 0, 32'h1234,   0, 32'h0, 1, 0, 0, 32'h0, 0));
        tbl.push_back(mk("irq_accept", 0, 1, 32'h80, 0, 32'h0, 0, 0, 0, 1, 32'h1234,  0, 32'h0, 1, 1, 0, 32'h0, 0));
        tbl.push_back(mk("irq_trap",   0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h1234,   1, 32'h200, 1, 1, 1, 32'h84, 1));
        tbl.push_back(mk("post_trap",  0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h1234,   0, 32'h0, 0, 0, 0, 32'h84, 0));
        tbl.push_back(mk("busy_irq",   0, 1, 32'h90, 0, 32'h0, 0, 1, 0, 1, 32'h1234,  0, 32'h0, 1, 0, 0, 32'h84, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("busy_pend", 0, 1, 32'h90, 0, 32'h0, 0, 1, 0, 0, 32'h1234, 0, 32'h0, 1, 0, 0, 32'h84, 0));
        tbl.push_back(mk("busy_accept", 0, 1, 32'h90, 1, 32'h300, 0, 0, 0, 0, 32'h1234, 1, 32'h300, 1, 1, 0, 32'h84, 0));
        tbl.push_back(mk("busy_trap",  0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h1234,   1, 32'h200, 1, 1, 1, 32'h300, 1));
        tbl.push_back(mk("mret_irq",   0, 1, 32'hA0, 0, 32'h0, 1, 0, 0, 1, 32'h1234,  1, 32'h1234, 0, 1, 0, 32'h300, 0));
        tbl.push_back(mk("wrap_accept", 0, 1, 32'hFFFFFFFC, 0, 32'h0, 0, 0, 0, 0, 32'h1234, 0, 32'h0, 1, 1, 0, 32'h300, 0));
        tbl.push_back(mk("trap_relatch", 0, 1, 32'h50, 1, 32'h500, 0, 0, 0, 1, 32'h1234, 1, 32'h200, 1, 1, 1, 32'h0, 1));
        tbl.push_back(mk("relatch_acc", 0, 1, 32'h10, 0, 32'h0, 0, 0, 0, 0, 32'h1234,  0, 32'h0, 1, 1, 0, 32'h0, 0));
        tbl.push_back(mk("relatch_trap", 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h1234,  1, 32'h200, 1, 1, 1, 32'h14, 1));
        tbl.push_back(mk("pend_clear", 0, 1, 32'h20, 0, 32'h0, 0, 0, 0, 0, 32'h1234,   0, 32'h0, 0, 0, 0, 32'h14, 0));
        tbl.push_back(mk("bubble_irq", 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1, 32'h1234,    0, 32'h0, 0, 0, 0, 32'h14, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset mid-trap: pending irq accepted, trap cycle, then reset.
        apply(mk("rt_accept", 0, 1, 32'h40, 0, 32'h0, 0, 0, 0, 0, 32'h1234, 0, 32'h0, 1, 1, 0, 32'h14, 0));
        apply(mk("rt_trap",   1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1, 32'h1234,  1, 32'h200, 1, 1, 1, 32'h44, 1));
        apply(mk("rt_after",  0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h1234,  0, 32'h0, 0, 0, 0, 32'h0, 0));
        apply(mk("rt_nopend", 0, 1, 32'h60, 0, 32'h0, 0, 0, 0, 0, 32'h1234, 0, 32'h0, 0, 0, 0, 32'h0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
